// File: rtl/cal_eeprom_spi_resp.sv
// SPI mode-0 responder backed by a 64x8 calibration EEPROM model.
// Reads are answered in the low byte of the next frame's MISO word.
module cal_eeprom_spi_resp #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic wr_pulse,
  output logic rd_pulse,
  output logic frame_err
);

  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int DEPTH   = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DECODE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           ss_q, ss_d;
  logic [2:0]           sclk_q, sclk_d;
  logic [1:0]           mosi_q, mosi_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   rx_q, rx_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [FRAME_W-1:0]   resp_q, resp_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 ss_fall;
  logic                 ss_rise;
  logic                 ss_hi;
  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 mosi_s;
  logic [1:0]           op;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    wdata;

  always_comb begin
    ss_d   = {ss_q[1:0], SS_n};
    sclk_d = {sclk_q[1:0], SCLK};
    mosi_d = {mosi_q[0], MOSI};
  end

  // Stage [1] is the synchronized level; stage [2] is its one-clk history.
  assign ss_hi     = ss_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign mosi_s    = mosi_q[1];

  assign op    = rx_q[FRAME_W-1 -: 2];
  assign addr  = rx_q[FRAME_W-3 -: ADDR_W];
  assign wdata = rx_q[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    resp_d    = resp_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          tx_d      = resp_q;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_d = {rx_q[FRAME_W-2:0], mosi_s};
          if (bit_cnt_q != CNT_W'(FRAME_W)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end
        // A final SCLK rise beats a coincident SS_n rise.
        if (sclk_rise && bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
          state_d = DECODE;
        end else if (ss_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DECODE: begin
        state_d = DONE;
        unique case (1'b1)
          (op == 2'b01): begin
            mem_we = 1'b1;
            wr_d   = 1'b1;
            resp_d = '0;
          end
          (op == 2'b00): begin
            resp_d = {{(FRAME_W-DATA_W){1'b0}}, mem[addr]};
            rd_d   = 1'b1;
          end
          default: begin
            resp_d = '0;
          end
        endcase
      end
      DONE: begin
        // Level test: the SS_n rise may have landed during DECODE.
        if (ss_hi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ss_q      <= '1;
      sclk_q    <= '0;
      mosi_q    <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      resp_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      resp_q    <= resp_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

  // Nonvolatile model: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wdata;
    end
  end

  assign MISO      = (state_q == ACTIVE) & tx_q[FRAME_W-1];
  assign wr_pulse  = wr_q;
  assign rd_pulse  = rd_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_cal_eeprom_spi_resp.sv
// Directed bench for cal_eeprom_spi_resp.
// SCLK half-period 50ns against a 10ns system clock.
module tb_cal_eeprom_spi_resp;

  logic clk;
  logic rst_n;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic wr_pulse;
  logic rd_pulse;
  logic frame_err;

  int n_chk;
  int n_pass;
  int wr_cnt;
  int rd_cnt;
  int err_cnt;

  cal_eeprom_spi_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .wr_pulse (wr_pulse),
    .rd_pulse (rd_pulse),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse)  wr_cnt++;
    if (rd_pulse)  rd_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic spi_frame(
    input  logic [15:0] tx,
    input  int          nbits,
    input  int          gap_ns,
    input  bit          hold_ss,
    output logic [15:0] rx
  );
    rx   = '0;
    SS_n = 1'b0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? tx[15-i] : 1'b0;
      #50;
      if (i < 16) rx[15-i] = MISO;
      SCLK = 1'b1;
      #50;
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    if (!hold_ss) begin
      #50;
      SS_n = 1'b1;
      #(gap_ns);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #37;
    n_chk++;
    if ({MISO, wr_pulse, rd_pulse, frame_err} !== 4'b0) begin
      $display("FAIL reset_outs got %b want 0000",
               {MISO, wr_pulse, rd_pulse, frame_err});
    end else n_pass++;
    rst_n = 1'b1;
    #100;
    n_chk++;
    if ({MISO, wr_cnt, rd_cnt, err_cnt} !== '0) begin
      $display("FAIL reset_idle miso=%b wr=%0d rd=%0d err=%0d want 0",
               MISO, wr_cnt, rd_cnt, err_cnt);
    end else n_pass++;
  endtask

  task automatic test_write;
    logic [15:0] rx;
    int w0;
    int r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    spi_frame(16'h4A5C, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h0000) begin
      $display("FAIL write_miso got %h want 0000", rx);
    end else n_pass++;
    n_chk++;
    if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin
      $display("FAIL write_pulses wr=%0d rd=%0d want 1 0",
               wr_cnt - w0, rd_cnt - r0);
    end else n_pass++;
    n_chk++;
    if (dut.mem[10] !== 8'h5C) begin
      $display("FAIL write_mem got %h want 5c", dut.mem[10]);
    end else n_pass++;
    n_chk++;
    if (MISO !== 1'b0) begin
      $display("FAIL desel_miso got %b want 0", MISO);
    end else n_pass++;
  endtask

  task automatic test_read;
    logic [15:0] rx;
    int r0;
    r0 = rd_cnt;
    spi_frame(16'h0A00, 16, 100, 1'b0, rx);
    n_chk++;
    if (rd_cnt - r0 !== 1 || rx !== 16'h0000) begin
      $display("FAIL read_f1 rd=%0d rx=%h want 1 0000", rd_cnt - r0, rx);
    end else n_pass++;
    spi_frame(16'h0000, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h005C) begin
      $display("FAIL read_f2 got %h want 005c", rx);
    end else n_pass++;
  endtask

  task automatic test_abort;
    logic [15:0] rx;
    int w0;
    int e0;
    spi_frame(16'h7F11, 16, 100, 1'b0, rx);
    w0 = wr_cnt;
    e0 = err_cnt;
    spi_frame(16'h7FFF, 9, 100, 1'b0, rx);
    n_chk++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0) begin
      $display("FAIL abort_pulses err=%0d wr=%0d want 1 0",
               err_cnt - e0, wr_cnt - w0);
    end else n_pass++;
    n_chk++;
    if (dut.mem[63] !== 8'h11) begin
      $display("FAIL abort_mem got %h want 11", dut.mem[63]);
    end else n_pass++;
  endtask

  task automatic test_bad_opcode;
    logic [15:0] rx;
    int w0;
    int r0;
    spi_frame(16'h0A00, 16, 100, 1'b0, rx);
    w0 = wr_cnt;
    r0 = rd_cnt;
    spi_frame(16'hC123, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h005C) begin
      $display("FAIL badop_resp got %h want 005c", rx);
    end else n_pass++;
    n_chk++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      $display("FAIL badop_pulses wr=%0d rd=%0d want 0 0",
               wr_cnt - w0, rd_cnt - r0);
    end else n_pass++;
    spi_frame(16'h0000, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h0000) begin
      $display("FAIL badop_next got %h want 0000", rx);
    end else n_pass++;
  endtask

  task automatic test_extra_sclk;
    logic [15:0] rx;
    int w0;
    int e0;
    w0 = wr_cnt;
    e0 = err_cnt;
    spi_frame(16'h4101, 20, 100, 1'b0, rx);
    n_chk++;
    if (wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
      $display("FAIL extra_pulses wr=%0d err=%0d want 1 0",
               wr_cnt - w0, err_cnt - e0);
    end else n_pass++;
    n_chk++;
    if (dut.mem[1] !== 8'h01) begin
      $display("FAIL extra_mem got %h want 01", dut.mem[1]);
    end else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] rx;
    int w0;
    int e0;
    spi_frame(16'h4533, 16, 100, 1'b0, rx);
    spi_frame(16'h0A00, 16, 100, 1'b0, rx);
    w0 = wr_cnt;
    e0 = err_cnt;
    spi_frame(16'h45AA, 8, 0, 1'b1, rx);
    rst_n = 1'b0;
    #20;
    n_chk++;
    if ({MISO, wr_pulse, rd_pulse, frame_err} !== 4'b0) begin
      $display("FAIL rstmid_outs got %b want 0000",
               {MISO, wr_pulse, rd_pulse, frame_err});
    end else n_pass++;
    SS_n = 1'b1;
    #50;
    rst_n = 1'b1;
    #100;
    n_chk++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0) begin
      $display("FAIL rstmid_pulses wr=%0d err=%0d want 0 0",
               wr_cnt - w0, err_cnt - e0);
    end else n_pass++;
    n_chk++;
    if (dut.mem[5] !== 8'h33) begin
      $display("FAIL rstmid_mem got %h want 33", dut.mem[5]);
    end else n_pass++;
    spi_frame(16'h0500, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h0000) begin
      $display("FAIL rstmid_resp got %h want 0000", rx);
    end else n_pass++;
    spi_frame(16'h0000, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h0033) begin
      $display("FAIL rstmid_read got %h want 0033", rx);
    end else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] rx;
    int r0;
    spi_frame(16'h4C77, 16, 40, 1'b0, rx);
    r0 = rd_cnt;
    spi_frame(16'h0C00, 16, 40, 1'b0, rx);
    spi_frame(16'h0A00, 16, 40, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h0077) begin
      $display("FAIL b2b_read1 got %h want 0077", rx);
    end else n_pass++;
    spi_frame(16'h0000, 16, 100, 1'b0, rx);
    n_chk++;
    if (rx !== 16'h005C) begin
      $display("FAIL b2b_read2 got %h want 005c", rx);
    end else n_pass++;
    n_chk++;
    if (rd_cnt - r0 !== 3) begin
      $display("FAIL b2b_rd_cnt got %0d want 3", rd_cnt - r0);
    end else n_pass++;
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b0;
    MOSI    = 1'b0;
    n_chk   = 0;
    n_pass  = 0;
    wr_cnt  = 0;
    rd_cnt  = 0;
    err_cnt = 0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_bad_opcode();
    test_extra_sclk();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
